// File: rtl/ask_frame_sequencer.sv
// ask_frame_sequencer
// Frame-level controller for the DDS ASK modulator.
// Each frame has three parts:
//   - an alternating preamble (1,0,1,0,...);
//   - the payload bytes, sent MSB first;
//   - a carrier-off guard interval.
// Every bit is held for a programmable number of clock cycles.
// Optional build macro: ASK_PARITY_EN appends an even-parity bit to every
// payload byte, giving 9 bits per byte instead of 8.
module ask_frame_sequencer #(
    parameter int PERIOD_W      = 16,
    parameter int PREAMBLE_BITS = 8,
    parameter int GUARD_BITS    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PERIOD_W-1:0] i_bit_period,
    input  logic [5:0]          i_carrier_word,
    input  logic [7:0]          i_byte,
    input  logic                i_last,
    input  logic                i_byte_valid,
    output logic                o_byte_ready,
    output logic                o_mod_data,
    output logic [5:0]          o_mod_freq_word,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_underrun
);

`ifdef ASK_PARITY_EN
    localparam int BITS_PER_BYTE = 9;
`else
    localparam int BITS_PER_BYTE = 8;
`endif
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_GUARD
    } state_t;

    state_t                   state_reg;
    logic [PERIOD_W-1:0]      period_reg;
    logic [PERIOD_W-1:0]      timer_reg;
    logic [CNT_W-1:0]         bit_cnt_reg;
    logic [BITS_PER_BYTE-1:0] shift_reg;
    logic                     last_reg;
    logic                     mod_data_reg;
    logic [5:0]               freq_word_reg;
    logic                     busy_reg;
    logic                     frame_done_reg;
    logic                     underrun_reg;

    logic [7:0]               hold_byte_reg;
    logic                     hold_last_reg;
    logic                     hold_valid_reg;

    logic [PERIOD_W-1:0]      period_eff;
    logic [BITS_PER_BYTE-1:0] load_word;
    logic                     bit_end;
    logic                     byte_end;
    logic                     shifter_load;
    logic                     accept;

    // Word presented to the shifter when a byte is taken from the holding register.
`ifdef ASK_PARITY_EN
    assign load_word = {hold_byte_reg, ^hold_byte_reg};
`else
    assign load_word = hold_byte_reg;
`endif

    assign o_byte_ready    = !hold_valid_reg;
    assign accept          = i_byte_valid && !hold_valid_reg;
    assign o_mod_data      = mod_data_reg;
    assign o_mod_freq_word = freq_word_reg;
    assign o_busy          = busy_reg;
    assign o_frame_done    = frame_done_reg;
    assign o_underrun      = underrun_reg;

    // Bit-boundary detection and the moments the shifter consumes the holding register.
    always_comb begin
        period_eff   = (i_bit_period == '0) ? PERIOD_W'(1) : i_bit_period;
        bit_end      = (timer_reg == '0);
        byte_end     = (bit_cnt_reg == CNT_W'(BITS_PER_BYTE - 1));
        shifter_load = 1'b0;
        if (state_reg == ST_IDLE && hold_valid_reg)
            shifter_load = 1'b1;
        else if (state_reg == ST_DATA && bit_end && byte_end && !last_reg && hold_valid_reg)
            shifter_load = 1'b1;
    end

    // One-entry holding register: a new accept takes priority over a shifter load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_byte_reg  <= '0;
            hold_last_reg  <= 1'b0;
            hold_valid_reg <= 1'b0;
        end else if (accept) begin
            hold_byte_reg  <= i_byte;
            hold_last_reg  <= i_last;
            hold_valid_reg <= 1'b1;
        end else if (shifter_load) begin
            hold_valid_reg <= 1'b0;
        end
    end

    // Frame FSM: sequences preamble/data/guard bits and drives registered modulator outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            period_reg     <= PERIOD_W'(1);
            timer_reg      <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            last_reg       <= 1'b0;
            mod_data_reg   <= 1'b0;
            freq_word_reg  <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (hold_valid_reg) begin
                        state_reg     <= ST_PREAMBLE;
                        period_reg    <= period_eff;
                        timer_reg     <= period_eff - PERIOD_W'(1);
                        bit_cnt_reg   <= '0;
                        shift_reg     <= load_word;
                        last_reg      <= hold_last_reg;
                        mod_data_reg  <= 1'b1;
                        freq_word_reg <= i_carrier_word;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (!bit_end) begin
                        timer_reg <= timer_reg - PERIOD_W'(1);
                    end else begin
                        timer_reg <= period_reg - PERIOD_W'(1);
                        if (bit_cnt_reg == CNT_W'(PREAMBLE_BITS - 1)) begin
                            state_reg    <= ST_DATA;
                            bit_cnt_reg  <= '0;
                            mod_data_reg <= shift_reg[BITS_PER_BYTE-1];
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
                            // Next preamble index is even (bit = 1) exactly when the current one is odd.
                            mod_data_reg <= bit_cnt_reg[0];
                        end
                    end
                end
                ST_DATA: begin
                    if (!bit_end) begin
                        timer_reg <= timer_reg - PERIOD_W'(1);
                    end else begin
                        timer_reg <= period_reg - PERIOD_W'(1);
                        if (byte_end) begin
                            bit_cnt_reg <= '0;
                            if (last_reg) begin
                                state_reg    <= ST_GUARD;
                                mod_data_reg <= 1'b0;
                            end else if (hold_valid_reg) begin
                                shift_reg    <= load_word;
                                last_reg     <= hold_last_reg;
                                mod_data_reg <= load_word[BITS_PER_BYTE-1];
                            end else begin
                                // Payload stream starved: close the frame with a guard interval.
                                state_reg    <= ST_GUARD;
                                mod_data_reg <= 1'b0;
                                underrun_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
                            shift_reg    <= {shift_reg[BITS_PER_BYTE-2:0], 1'b0};
                            mod_data_reg <= shift_reg[BITS_PER_BYTE-2];
                        end
                    end
                end
                ST_GUARD: begin
                    if (!bit_end) begin
                        timer_reg <= timer_reg - PERIOD_W'(1);
                    end else begin
                        timer_reg <= period_reg - PERIOD_W'(1);
                        if (bit_cnt_reg == CNT_W'(GUARD_BITS - 1)) begin
                            state_reg      <= ST_IDLE;
                            bit_cnt_reg    <= '0;
                            freq_word_reg  <= '0;
                            busy_reg       <= 1'b0;
                            frame_done_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ask_frame_sequencer.sv
// tb_ask_frame_sequencer
// Directed bench for ask_frame_sequencer.
// Each frame is checked cycle by cycle against a hand-written payload bit
// string and against the expected frame length.
// Build with ASK_PARITY_EN to exercise the parity variant.
module tb_ask_frame_sequencer;

    localparam int PERIOD_W = 16;
    localparam int PRE      = 8;
    localparam int GRD      = 4;
`ifdef ASK_PARITY_EN
    localparam int PB = 9;
    // All bytes below except 0x07 have an even number of ones, so their parity bit is 0.
    localparam logic [31:0] PAY_A5   = 32'b1010_0101_0;
    localparam logic [31:0] PAY_3C   = 32'b0011_1100_0;
    localparam logic [31:0] PAY_3CF0 = 32'b0011_1100_0_1111_0000_0;
    localparam logic [31:0] PAY_81   = 32'b1000_0001_0;
    localparam logic [31:0] PAY_5A   = 32'b0101_1010_0;
`else
    localparam int PB = 8;
    localparam logic [31:0] PAY_A5   = 32'b1010_0101;
    localparam logic [31:0] PAY_3C   = 32'b0011_1100;
    localparam logic [31:0] PAY_3CF0 = 32'b0011_1100_1111_0000;
    localparam logic [31:0] PAY_81   = 32'b1000_0001;
    localparam logic [31:0] PAY_5A   = 32'b0101_1010;
`endif

    logic                i_clk;
    logic                i_rst_n;
    logic [PERIOD_W-1:0] i_bit_period;
    logic [5:0]          i_carrier_word;
    logic [7:0]          i_byte;
    logic                i_last;
    logic                i_byte_valid;
    logic                o_byte_ready;
    logic                o_mod_data;
    logic [5:0]          o_mod_freq_word;
    logic                o_busy;
    logic                o_frame_done;
    logic                o_underrun;

    int n_cmp = 0;
    int n_mis = 0;

    ask_frame_sequencer #(
        .PERIOD_W      (PERIOD_W),
        .PREAMBLE_BITS (PRE),
        .GUARD_BITS    (GRD)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_bit_period    (i_bit_period),
        .i_carrier_word  (i_carrier_word),
        .i_byte          (i_byte),
        .i_last          (i_last),
        .i_byte_valid    (i_byte_valid),
        .o_byte_ready    (o_byte_ready),
        .o_mod_data      (o_mod_data),
        .o_mod_freq_word (o_mod_freq_word),
        .o_busy          (o_busy),
        .o_frame_done    (o_frame_done),
        .o_underrun      (o_underrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte in IDLE.
    // It is accepted at edge E0. The task returns at the falling edge
    // after E0, so the next falling edge follows E1.
    task automatic send_first(input logic [7:0] b, input logic last);
        @(negedge i_clk);
        i_byte       = b;
        i_last       = last;
        i_byte_valid = 1'b1;
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        check("start_ready", {31'd0, o_byte_ready}, 32'd0);
        check("start_busy", {31'd0, o_busy}, 32'd0);
    endtask

    // Follow a frame from E1 to its o_frame_done cycle.
    // The sample at k reflects the outputs just after edge E1+k. The packed
    // word is {busy, frame_done, underrun, freq_word, mod_data}.
    task automatic watch_frame(input int p, input logic [5:0] word, input logic [31:0] payload,
                               input int npay, input int ur_k, input string name);
        int   len;
        int   idx;
        logic bit_exp;
        logic [9:0] got;
        logic [9:0] exp;
        len = p * (PRE + npay + GRD);
        for (int k = 0; k <= len; k++) begin
            @(negedge i_clk);
            got = {o_busy, o_frame_done, o_underrun, o_mod_freq_word, o_mod_data};
            if (k < len) begin
                idx = k / p;
                if (idx < PRE)             bit_exp = (idx % 2 == 0);
                else if (idx < PRE + npay) bit_exp = payload[npay - 1 - (idx - PRE)];
                else                       bit_exp = 1'b0;
                exp = {1'b1, 1'b0, (k == ur_k), word, bit_exp};
            end else begin
                exp = 10'b01_0_000000_0;
            end
            check($sformatf("%s k=%0d", name, k), {22'd0, got}, {22'd0, exp});
        end
        $display("frame %s: period %0d, %0d payload bits, %0d cycles checked", name, p, npay, len + 1);
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_bit_period   = '0;
        i_carrier_word = '0;
        i_byte         = '0;
        i_last         = 1'b0;
        i_byte_valid   = 1'b0;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_mod_data", {31'd0, o_mod_data}, 32'd0);
        check("rst_freq", {26'd0, o_mod_freq_word}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_frame_done}, 32'd0);
        check("rst_underrun", {31'd0, o_underrun}, 32'd0);
        check("rst_ready", {31'd0, o_byte_ready}, 32'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Period 4, word 20, single byte 0xA5 with last.
        // Period and word change mid-frame and must be ignored.
        i_bit_period   = 16'd4;
        i_carrier_word = 6'd20;
        send_first(8'hA5, 1'b1);
        fork
            watch_frame(4, 6'd20, PAY_A5, PB, -1, "a5_p4");
            begin
                repeat (3) @(negedge i_clk);
                i_bit_period   = 16'd7;
                i_carrier_word = 6'd3;
            end
        join
        check("idle_ready", {31'd0, o_byte_ready}, 32'd1);

        // Period 0 behaves as period 1
        i_bit_period   = 16'd0;
        i_carrier_word = 6'd63;
        send_first(8'hA5, 1'b1);
        watch_frame(1, 6'd63, PAY_A5, PB, -1, "a5_p0");

        // Two-byte frame; the second byte is presented during the first byte's DATA
        i_bit_period   = 16'd4;
        i_carrier_word = 6'd20;
        send_first(8'h3C, 1'b0);
        fork
            watch_frame(4, 6'd20, PAY_3CF0, 2 * PB, -1, "3c_f0");
            begin
                repeat (4 * PRE + 5) @(negedge i_clk);
                i_byte       = 8'hF0;
                i_last       = 1'b1;
                i_byte_valid = 1'b1;
                @(negedge i_clk);
                i_byte_valid = 1'b0;
            end
        join

        // Second byte withheld: underrun after the first byte, then the guard interval
        send_first(8'h3C, 1'b0);
        watch_frame(4, 6'd20, PAY_3C, PB, 4 * (PRE + PB), "3c_underrun");

        // Reset asserted mid-DATA
        i_carrier_word = 6'd5;
        send_first(8'h81, 1'b1);
        repeat (4 * PRE + 1) @(negedge i_clk);
        check("pre_rst_mod", {31'd0, o_mod_data}, 32'd1);
        check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_mod", {31'd0, o_mod_data}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_ready", {31'd0, o_byte_ready}, 32'd1);
        check("mid_rst_freq", {26'd0, o_mod_freq_word}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // A new frame after reset runs normally
        i_bit_period   = 16'd2;
        i_carrier_word = 6'd9;
        send_first(8'h5A, 1'b1);
        watch_frame(2, 6'd9, PAY_5A, PB, -1, "5a_after_rst");

`ifdef ASK_PARITY_EN
        // Byte 0x07 carries parity bit 1; period 4 gives frame_done at E1+84
        i_bit_period   = 16'd4;
        i_carrier_word = 6'd20;
        send_first(8'h07, 1'b1);
        watch_frame(4, 6'd20, 32'b0000_0111_1, 9, -1, "07_parity");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ask_frame_sequencer.md
# ask_frame_sequencer

Frame-level controller for the DDS ASK modulator. It accepts payload bytes over a valid/ready handshake and builds each frame from three parts: an alternating preamble, the payload serialized MSB-first, and a carrier-off guard interval. For each bit it drives the modulator's data-enable and carrier frequency word, holding every bit for a programmable number of clock cycles. It sits directly upstream of the modulator: `o_mod_data` feeds `i_data` and `o_mod_freq_word` feeds `i_freq_word`.

## Interface
- PERIOD_W, 16, width of the bit-period count
- PREAMBLE_BITS, 8, number of preamble bits (1,0,1,0,…; first bit is 1), must be ≥1
- GUARD_BITS, 4, number of carrier-off bit periods after each frame, must be ≥1
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_bit_period  in  PERIOD_W  cycles per bit; sampled at frame start; 0 is treated as 1
- i_carrier_word  in  6  carrier frequency word; sampled at frame start
- i_byte  in  8  payload byte
- i_last  in  1  marks i_byte as the final byte of the frame
- i_byte_valid  in  1  i_byte/i_last are valid
- o_byte_ready  out  1  holding register empty; transfer occurs when valid && ready at a rising edge
- o_mod_data  out  1  bit to modulator (1 = carrier on)
- o_mod_freq_word  out  6  frequency word to modulator
- o_busy  out  1  high in every state except IDLE
- o_frame_done  out  1  one-cycle pulse when guard completes
- o_underrun  out  1  one-cycle pulse when the payload stream is starved mid-frame

## Operation
- One-entry holding register {byte, last, valid}.
  - o_byte_ready = !hold_valid, independent of state, so the first byte of the next frame may be accepted during GUARD.
- The shift register loads from the holding register at each byte boundary; this load clears hold_valid.
- States and transitions:
  - IDLE → PREAMBLE when hold_valid. On this transition, latch period (0→1) and carrier word, and load the first byte into the shifter.
  - PREAMBLE → DATA after PREAMBLE_BITS bits.
  - DATA: shift MSB first, 8 bits per byte (9 with parity, see Configuration).
    - At the end of a byte's last bit: if that byte was marked last → GUARD.
    - Else if hold_valid → load the next byte and stay in DATA.
    - Else → pulse o_underrun and go to GUARD.
  - GUARD → IDLE after GUARD_BITS bits; pulse o_frame_done on the cycle IDLE is entered.
- o_mod_data values:
  - PREAMBLE: current preamble bit.
  - DATA: shifter MSB.
  - GUARD and IDLE: 0.
- o_mod_freq_word: latched word in PREAMBLE/DATA/GUARD; 0 in IDLE.
- Bit timer counts down from period−1 and reloads on each bit boundary. Each bit is held exactly `period` cycles.
- Period and carrier word changes after frame start are ignored until the next frame.

## Timing
- Reset values (asserted asynchronously, any state, including mid-frame):
  - state IDLE.
  - o_mod_data 0, o_mod_freq_word 0, o_busy 0, o_frame_done 0, o_underrun 0.
  - hold_valid 0, so o_byte_ready 1.
  - In-flight frame discarded.
- All outputs except o_byte_ready are registered.
- Frame start latency:
  - The byte is accepted at edge E0 (in IDLE); the state is IDLE with hold_valid at E0+.
  - At edge E1, the FSM enters PREAMBLE: o_busy=1, o_mod_data=1, o_mod_freq_word valid.
- Frame length in cycles: period × (PREAMBLE_BITS + N×bits_per_byte + GUARD_BITS). o_frame_done pulses at E1 + that count.
- Next-byte deadline: the byte must be in the holding register by the edge ending the current byte's final bit. A byte arriving on that same edge is too late and counts as an underrun.
- A simultaneous accept and shifter load on one edge is legal; hold_valid ends at 1 (the new byte).
- Back-to-back frames: if hold_valid is set in IDLE, the next PREAMBLE starts one cycle after o_frame_done.
- i_last on an accepted byte is honoured even when that byte is the first byte (single-byte frame).

## Configuration
- ASK_PARITY_EN defined: each byte is followed by an even-parity bit (XOR of the 8 data bits), giving 9 bits per byte.
- Undefined: 8 bits per byte, no parity logic.
- Underrun and last-byte checks occur after the parity bit when parity is enabled.

## Test plan
- Period 4, word 6'd20, single byte 0xA5 with last, defaults:
  - o_mod_data sequence is 10101010, then 10100101, then 0000.
  - Each bit lasts 4 cycles.
  - o_frame_done at E1+80; o_mod_freq_word = 20 from E1 to E1+79, then 0.
- Period 0: each bit lasts 1 cycle; o_frame_done at E1+20.
- Two-byte frame 0x3C, 0xF0(last), second byte presented during first byte's DATA:
  - Payload bits are 0011110011110000; no underrun.
- Same frame, second byte withheld:
  - o_underrun pulses at the end of bit 8 of the payload; GUARD follows.
  - o_frame_done pulses GUARD_BITS×period cycles later.
- Deassert i_rst_n mid-DATA:
  - Immediately o_mod_data=0, o_busy=0, o_byte_ready=1.
  - After release, a new frame runs normally.
- ASK_PARITY_EN, byte 0x07 last:
  - Payload bits are 000001111, with parity bit 1.
  - With period 4, o_frame_done at E1+84.
